// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU codes, result-select codes and mul/div FSM encoding
package mips_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_MULT  = 4'd11;
  localparam logic [3:0] ALU_MULTU = 4'd12;
  localparam logic [3:0] ALU_DIV   = 4'd13;
  localparam logic [3:0] ALU_DIVU  = 4'd14;
  localparam logic [3:0] ALU_LUI   = 4'd15;

  // Result source select, muxctrl[1:0]; 11 is an alias of the ALU path
  localparam logic [1:0] SEL_ALU     = 2'b00;
  localparam logic [1:0] SEL_HI      = 2'b01;
  localparam logic [1:0] SEL_LO      = 2'b10;
  localparam logic [1:0] SEL_ALU_ALT = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // Mul/div unit operation encoding
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  function automatic logic is_muldiv(input logic [3:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) ||
           (code == ALU_DIV)  || (code == ALU_DIVU);
  endfunction

  function automatic logic [1:0] muldiv_op(input logic [3:0] code);
    case (code)
      ALU_MULTU: return MD_MULTU;
      ALU_DIV:   return MD_DIV;
      ALU_DIVU:  return MD_DIVU;
      default:   return MD_MULT;
    endcase
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide with HI/LO
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] LAST_STEP = 5'(MULDIV_CYCLES - 1);

  md_state_t   state, state_next;
  logic [4:0]  count;
  logic [63:0] acc;          // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [31:0] opb_mag;      // multiplicand or divisor magnitude
  logic [31:0] raw_a;        // original dividend, returned in HI on divide by zero
  logic [1:0]  op_q;
  logic        neg_q;        // negate product / quotient
  logic        neg_r;        // negate remainder
  logic        div_zero;

  logic        sgn;
  logic [31:0] a_mag, b_mag;
  logic        is_mul;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [64:0] div_shift;
  logic [32:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_next;
  end

  // Next state: a start is only honoured in IDLE, so DONE never re-accepts
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (count == LAST_STEP) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // State decode outputs
  always_comb begin
    idle = (state == MD_IDLE);
    busy = (state == MD_BUSY);
    done = (state == MD_DONE);
  end

  // Operand magnitudes, one iteration step and final sign fixup
  always_comb begin
    sgn       = op_is_signed(op);
    a_mag     = (sgn && a[31]) ? (~a + 32'd1) : a;
    b_mag     = (sgn && b[31]) ? (~b + 32'd1) : b;
    is_mul    = (op_q == MD_MULT) || (op_q == MD_MULTU);

    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opb_mag : 32'd0)};
    mul_next  = {mul_sum, acc[31:1]};

    div_shift = {acc, 1'b0};
    div_trial = div_shift[64:32] - {1'b0, opb_mag};
    div_next  = div_trial[32] ? div_shift[63:0]
                              : {div_trial[31:0], div_shift[31:1], 1'b1};

    prod      = neg_q ? (~acc + 64'd1) : acc;
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (div_zero) begin
      res_hi = raw_a;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_lo = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
      res_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    end
  end

  // Datapath: latch operands in IDLE, iterate in BUSY, commit HI/LO in DONE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= 5'd0;
      acc      <= 64'd0;
      opb_mag  <= 32'd0;
      raw_a    <= 32'd0;
      op_q     <= 2'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            count    <= 5'd0;
            acc      <= {32'd0, a_mag};
            opb_mag  <= b_mag;
            raw_a    <= a;
            op_q     <= op;
            neg_q    <= sgn && (a[31] ^ b[31]);
            neg_r    <= sgn && a[31];
            div_zero <= op[1] && (b == 32'd0);
          end
        end
        MD_BUSY: begin
          acc   <= is_mul ? mul_next : div_next;
          count <= count + 5'd1;
        end
        MD_DONE: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, result mux, bubble insertion, EX/MEM registers
module ex_stage
  import mips_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] d1_in,
  input  logic [31:0] d2_in,
  input  logic [4:0]  rd_in,
  input  logic [3:0]  aluctrl_in,
  input  logic [7:0]  muxctrl_in,
  input  logic [2:0]  memctrl_in,
  output logic [31:0] alu_out,
  output logic [31:0] d2_out,
  output logic [4:0]  rd_out,
  output logic [7:0]  muxctrl_out,
  output logic [2:0]  memctrl_out,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [31:0] alu_res;
  logic [31:0] result;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_idle, md_busy, md_done;
  logic [31:0] hi, lo;
  logic        bubble;

  assign md_start = is_muldiv(aluctrl_in);
  assign md_op    = muldiv_op(aluctrl_in);

  muldiv_unit #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv (
    .clock (clock),
    .reset (reset),
    .start (md_start),
    .op    (md_op),
    .a     (d1_in),
    .b     (d2_in),
    .idle  (md_idle),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (hi),
    .lo    (lo)
  );

  assign hi_out = hi;
  assign lo_out = lo;

  // Hold the front end while a mul/div is being accepted or iterating; never during reset
  assign stall  = ~reset & ((md_idle & md_start) | md_busy);
  // A retiring mul/div has no GPR writeback, so it leaves as a bubble too
  assign bubble = stall | md_done;

  // Single-cycle ALU; mul/div codes produce 0 here since they only write HI/LO
  always_comb begin
    alu_res = 32'd0;
    case (aluctrl_in)
      ALU_ADD:  alu_res = d1_in + d2_in;
      ALU_SUB:  alu_res = d1_in - d2_in;
      ALU_AND:  alu_res = d1_in & d2_in;
      ALU_OR:   alu_res = d1_in | d2_in;
      ALU_XOR:  alu_res = d1_in ^ d2_in;
      ALU_NOR:  alu_res = ~(d1_in | d2_in);
      ALU_SLT:  alu_res = {31'd0, $signed(d1_in) < $signed(d2_in)};
      ALU_SLTU: alu_res = {31'd0, d1_in < d2_in};
      ALU_SLL:  alu_res = d2_in << d1_in[4:0];
      ALU_SRL:  alu_res = d2_in >> d1_in[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(d2_in) >>> d1_in[4:0]);
      ALU_LUI:  alu_res = {d2_in[15:0], 16'd0};
      default:  alu_res = 32'd0;
    endcase
  end

  // Result source select
  always_comb begin
    result = alu_res;
    case (muxctrl_in[1:0])
      SEL_ALU:     result = alu_res;
      SEL_HI:      result = hi;
      SEL_LO:      result = lo;
      SEL_ALU_ALT: result = alu_res;
      default:     result = alu_res;
    endcase
  end

  // EX/MEM register with bubble insertion; store data always follows the input
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_out     <= 32'd0;
      d2_out      <= 32'd0;
      rd_out      <= 5'd0;
      muxctrl_out <= 8'd0;
      memctrl_out <= 3'd0;
    end else begin
      d2_out <= d2_in;
      if (bubble) begin
        alu_out     <= 32'd0;
        rd_out      <= 5'd0;
        muxctrl_out <= 8'd0;
        memctrl_out <= 3'd0;
      end else begin
        alu_out     <= result;
        rd_out      <= rd_in;
        muxctrl_out <= muxctrl_in;
        memctrl_out <= memctrl_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage
module tb_ex_stage;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8, OP_SRL = 4'd9, OP_SRA = 4'd10, OP_MULT = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12, OP_DIV = 4'd13, OP_DIVU = 4'd14, OP_LUI = 4'd15;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] d1_in, d2_in;
  logic [4:0]  rd_in;
  logic [3:0]  aluctrl_in;
  logic [7:0]  muxctrl_in;
  logic [2:0]  memctrl_in;
  logic [31:0] alu_out, d2_out, hi_out, lo_out;
  logic [4:0]  rd_out;
  logic [7:0]  muxctrl_out;
  logic [2:0]  memctrl_out;
  logic        stall;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic [7:0]  mux;
    logic [2:0]  mem;
  } ex_t;

  ex_t exp_q[$];
  ex_t obs_q[$];
  int  checks = 0;
  int  errors = 0;

  ex_stage dut (
    .clock       (clock),
    .reset       (reset),
    .d1_in       (d1_in),
    .d2_in       (d2_in),
    .rd_in       (rd_in),
    .aluctrl_in  (aluctrl_in),
    .muxctrl_in  (muxctrl_in),
    .memctrl_in  (memctrl_in),
    .alu_out     (alu_out),
    .d2_out      (d2_out),
    .rd_out      (rd_out),
    .muxctrl_out (muxctrl_out),
    .memctrl_out (memctrl_out),
    .stall       (stall),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic set_nop();
    aluctrl_in = OP_ADD; d1_in = 0; d2_in = 0; rd_in = 0; muxctrl_in = 0; memctrl_in = 0;
  endtask

  // Drive one single-cycle instruction, push its expectation, capture what the DUT registers
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [7:0] mux, input logic [2:0] mem,
                       input logic [31:0] exp_alu);
    ex_t e, o;
    aluctrl_in = op; d1_in = a; d2_in = b; rd_in = rd; muxctrl_in = mux; memctrl_in = mem;
    e = '{alu: exp_alu, d2: b, rd: rd, mux: mux, mem: mem};
    exp_q.push_back(e);
    @(posedge clock); #1;
    o = '{alu: alu_out, d2: d2_out, rd: rd_out, mux: muxctrl_out, mem: memctrl_out};
    obs_q.push_back(o);
  endtask

  // Hold a mul/div on the inputs until it retires; report stall length and non-bubble outputs
  task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int stall_cycles, output int bubble_bad);
    aluctrl_in = op; d1_in = a; d2_in = b; rd_in = 5'd9; muxctrl_in = 8'h00; memctrl_in = 3'd2;
    stall_cycles = 0;
    bubble_bad   = 0;
    #1;
    for (int i = 0; i < 200 && stall === 1'b1; i++) begin
      stall_cycles++;
      @(posedge clock); #1;
      if (rd_out !== 5'd0 || alu_out !== 32'd0 || memctrl_out !== 3'd0) bubble_bad++;
    end
    @(posedge clock); #1;
    if (rd_out !== 5'd0 || alu_out !== 32'd0 || memctrl_out !== 3'd0) bubble_bad++;
  endtask

  task automatic test_reset();
    set_nop();
    d2_in = 32'hDEAD_BEEF;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({alu_out, d2_out, rd_out, muxctrl_out, memctrl_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got alu=%h d2=%h rd=%0d mux=%h mem=%0d want all 0",
               alu_out, d2_out, rd_out, muxctrl_out, memctrl_out);
    end
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_hilo got hi=%h lo=%h stall=%b want 0 0 0", hi_out, lo_out, stall);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    ex_t e, o;
    issue(OP_ADD,  32'h7FFF_FFFF, 32'h1,         5'd5,  8'hA4, 3'd3, 32'h8000_0000);
    issue(OP_SUB,  32'd5,         32'd7,         5'd1,  8'h00, 3'd0, 32'hFFFF_FFFE);
    issue(OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 5'd2,  8'h00, 3'd0, 32'h0000_F000);
    issue(OP_OR,   32'h0000_F0F0, 32'h0000_FF00, 5'd3,  8'h00, 3'd0, 32'h0000_FFF0);
    issue(OP_XOR,  32'h0000_F0F0, 32'h0000_FF00, 5'd4,  8'h03, 3'd0, 32'h0000_0FF0);
    issue(OP_NOR,  32'h0,         32'h0,         5'd6,  8'h00, 3'd1, 32'hFFFF_FFFF);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'h1,         5'd7,  8'h00, 3'd0, 32'h1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd8,  8'h00, 3'd0, 32'h0);
    issue(OP_SLL,  32'h24,        32'h1,         5'd10, 8'h00, 3'd0, 32'h10);
    issue(OP_SRL,  32'h4,         32'h8000_0000, 5'd11, 8'h00, 3'd0, 32'h0800_0000);
    issue(OP_SRA,  32'h4,         32'h8000_0000, 5'd12, 8'h00, 3'd0, 32'hF800_0000);
    issue(OP_LUI,  32'h0,         32'h1234,      5'd13, 8'h00, 3'd0, 32'h1234_0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL alu_op got alu=%h d2=%h rd=%0d mux=%h mem=%0d want alu=%h d2=%h rd=%0d mux=%h mem=%0d",
                 o.alu, o.d2, o.rd, o.mux, o.mem, e.alu, e.d2, e.rd, e.mux, e.mem);
      end
    end
  endtask

  task automatic test_mult_then_mf();
    int sc, bb;
    ex_t e, o;
    run_muldiv(OP_MULT, 32'hFFFF_FFFD, 32'd7, sc, bb);
    checks++;
    if (sc !== 33) begin errors++; $display("FAIL mult_stall_cycles got %0d want 33", sc); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL mult_bubble got %0d non-bubble cycles want 0", bb); end
    checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_hilo got hi=%h lo=%h want hi=ffffffff lo=ffffffeb", hi_out, lo_out);
    end
    issue(OP_ADD, 32'h11, 32'h22, 5'd3, 8'h02, 3'd0, 32'hFFFF_FFEB);
    issue(OP_ADD, 32'h11, 32'h22, 5'd4, 8'h01, 3'd0, 32'hFFFF_FFFF);
    issue(OP_ADD, 32'h11, 32'h22, 5'd5, 8'h03, 3'd0, 32'h33);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mfhilo got alu=%h d2=%h rd=%0d mux=%h mem=%0d want alu=%h d2=%h rd=%0d mux=%h mem=%0d",
                 o.alu, o.d2, o.rd, o.mux, o.mem, e.alu, e.d2, e.rd, e.mux, e.mem);
      end
    end
  endtask

  task automatic test_div();
    logic [3:0]  ops  [5] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    logic [31:0] av   [5] = '{32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'd100};
    logic [31:0] bv   [5] = '{32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] ehi  [5] = '{32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0, 32'd2};
    logic [31:0] elo  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd14};
    int sc, bb;
    for (int i = 0; i < 5; i++) begin
      run_muldiv(ops[i], av[i], bv[i], sc, bb);
      set_nop();
      checks++;
      if (hi_out !== ehi[i] || lo_out !== elo[i] || sc !== 33) begin
        errors++;
        $display("FAIL div_%0d got hi=%h lo=%h stall=%0d want hi=%h lo=%h stall=33",
                 i, hi_out, lo_out, sc, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    aluctrl_in = OP_MULTU; d1_in = 32'h1234_5678; d2_in = 32'h100; rd_in = 5'd9;
    muxctrl_in = 0; memctrl_in = 0;
    repeat (11) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({alu_out, d2_out, rd_out, muxctrl_out, memctrl_out} !== '0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got alu=%h d2=%h rd=%0d mux=%h mem=%0d stall=%b want all 0",
               alu_out, d2_out, rd_out, muxctrl_out, memctrl_out, stall);
    end
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_hilo got hi=%h lo=%h want 0 0", hi_out, lo_out);
    end
    set_nop();
    #3;
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon got hi=%h lo=%h stall=%b want 0 0 0", hi_out, lo_out, stall);
    end
  endtask

  task automatic test_back_to_back();
    int sc, bb;
    run_muldiv(OP_MULTU, 32'h1234_5678, 32'h100, sc, bb);
    checks++;
    if (hi_out !== 32'h12 || lo_out !== 32'h3456_7800 || sc !== 33 || bb !== 0) begin
      errors++;
      $display("FAIL b2b_first got hi=%h lo=%h stall=%0d bubble_bad=%0d want hi=12 lo=34567800 stall=33 0",
               hi_out, lo_out, sc, bb);
    end
    run_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc, bb);
    set_nop();
    checks++;
    if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h1 || sc !== 33 || bb !== 0) begin
      errors++;
      $display("FAIL b2b_second got hi=%h lo=%h stall=%0d bubble_bad=%0d want hi=fffffffe lo=1 stall=33 0",
               hi_out, lo_out, sc, bb);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_nop();
    test_reset();
    test_alu();
    test_mult_then_mf();
    test_div();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
